// File: rtl/alu_result_reader.sv
// Buffers verified 16-bit calculator results and streams each one out as two bytes, high byte first.
// Results whose complement output does not match are dropped and flagged.
module alu_result_reader #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [15:0]              Q,
    input  logic [15:0]              Qbar,
    output logic [7:0]               out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     out_last,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     err,
    output logic [7:0]               drop_cnt,
    output logic [0:0]               state_dbg
);

    localparam int AW = $clog2(DEPTH);

    localparam logic [0:0] ST_HI = 1'b0;
    localparam logic [0:0] ST_LO = 1'b1;

    localparam logic [AW:0]   FULL  = DEPTH[AW:0];
    localparam logic [AW:0]   ONE_C = 1;
    localparam logic [AW-1:0] ONE_P = 1;

    logic [15:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [0:0]    state;
    logic          armed;
    logic          push_try;
    logic          word_ok;
    logic          push;
    logic          drop;
    logic          pop;
    logic [15:0]   head;

    // Handshakes: a transfer happens on a rising edge where valid and ready are
    // both 1; ready never depends on valid in the same cycle, and a source holds
    // its data stable while valid=1 and ready=0.

    // armed keeps in_ready low while reset is held and for the release edge itself.
    assign in_ready  = armed && (count < FULL);
    assign out_valid = (count != '0);

    assign push_try = in_valid && in_ready;
    assign word_ok  = (Qbar == ~Q);
    assign push     = push_try && word_ok;
    assign drop     = push_try && !word_ok;
    assign pop      = out_valid && out_ready && (state == ST_LO);

    assign head      = mem[rd_ptr];
    assign out_data  = (state == ST_HI) ? head[15:8] : head[7:0];
    assign out_last  = (state == ST_LO);
    assign state_dbg = state;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= Q;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            armed <= 1'b0;
        end else begin
            armed <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + ONE_P;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + ONE_P;
            end
            case ({push, pop})
                2'b10:   count <= count + ONE_C;
                2'b01:   count <= count - ONE_C;
                default: count <= count;
            endcase
        end
    end

    // FSM only moves on an accepted byte, so it cannot leave HI while the buffer is empty.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_HI;
        end else if (out_valid && out_ready) begin
            state <= (state == ST_HI) ? ST_LO : ST_HI;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            err      <= 1'b0;
            drop_cnt <= '0;
        end else if (drop) begin
            err <= 1'b1;
            if (drop_cnt != 8'hFF) begin
                drop_cnt <= drop_cnt + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_alu_result_reader.sv
// Bench for alu_result_reader: directed scenarios plus a randomized run checked
// against a byte-queue reference model.
module tb_alu_result_reader;

    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          clk;
    logic          reset;
    logic          in_valid;
    logic          in_ready;
    logic [15:0]   Q;
    logic [15:0]   Qbar;
    logic [7:0]    out_data;
    logic          out_valid;
    logic          out_ready;
    logic          out_last;
    logic [CW-1:0] count;
    logic          err;
    logic [7:0]    drop_cnt;
    logic [0:0]    state_dbg;

    int errors;
    int checks;

    // Reference model: the pending output byte stream plus the sticky flags.
    logic [7:0] exp_q[$];
    bit         m_en;
    bit         m_err;
    int         m_drop;

    alu_result_reader #(.DEPTH(DEPTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .Q         (Q),
        .Qbar      (Qbar),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_last  (out_last),
        .count     (count),
        .err       (err),
        .drop_cnt  (drop_cnt),
        .state_dbg (state_dbg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int m_count();
        return (exp_q.size() + 1) / 2;
    endfunction

    task automatic model_clear();
        exp_q.delete();
        m_en   = 0;
        m_err  = 0;
        m_drop = 0;
    endtask

    task automatic model_step();
        int         cnt;
        bit         rdy;
        logic [7:0] tmp;
        cnt = m_count();
        rdy = m_en && (cnt < DEPTH);
        if (cnt != 0 && out_ready) tmp = exp_q.pop_front();
        if (in_valid && rdy) begin
            if (Qbar == ~Q) begin
                exp_q.push_back(Q[15:8]);
                exp_q.push_back(Q[7:0]);
            end else begin
                m_err = 1;
                if (m_drop < 255) m_drop++;
            end
        end
        m_en = 1;
    endtask

    task automatic drive(input logic iv, input logic [15:0] q, input logic [15:0] qb,
                         input logic ordy);
        @(negedge clk);
        in_valid  = iv;
        Q         = q;
        Qbar      = qb;
        out_ready = ordy;
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        checks++; if (count !== '0) begin errors++; $display("FAIL rst_count got=%0d exp=0", count); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got=%b exp=0", out_valid); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rst_in_ready got=%b exp=0", in_ready); end
        checks++; if (out_last !== 1'b0) begin errors++; $display("FAIL rst_out_last got=%b exp=0", out_last); end
        checks++; if (err !== 1'b0 || drop_cnt !== 8'd0) begin errors++; $display("FAIL rst_err got=%b/%0d exp=0/0", err, drop_cnt); end
        checks++; if (state_dbg !== 1'b0) begin errors++; $display("FAIL rst_state got=%b exp=0", state_dbg); end
        reset = 1'b1;
        tick();
        drive(0, 16'h0, 16'h0, 1);
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_release_ready got=%b exp=1", in_ready); end
    endtask

    task automatic test_single();
        drive(1, 16'h0140, 16'hFEBF, 1);
        tick();
        drive(0, 16'h0, 16'h0, 1);
        checks++; if (out_valid !== 1'b1 || out_data !== 8'h01 || out_last !== 1'b0) begin
            errors++; $display("FAIL single_hi got=%b/%h/%b exp=1/01/0", out_valid, out_data, out_last); end
        tick();
        drive(0, 16'h0, 16'h0, 1);
        checks++; if (out_data !== 8'h40 || out_last !== 1'b1) begin
            errors++; $display("FAIL single_lo got=%h/%b exp=40/1", out_data, out_last); end
        tick();
        drive(0, 16'h0, 16'h0, 1);
        checks++; if (count !== '0 || out_valid !== 1'b0) begin
            errors++; $display("FAIL single_empty got=%0d/%b exp=0/0", count, out_valid); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] eb[4];
        logic       el[4];
        eb = '{8'h00, 8'h0B, 8'h9C, 8'h40};
        el = '{1'b0, 1'b1, 1'b0, 1'b1};
        drive(1, 16'h000B, 16'hFFF4, 1);
        tick();
        drive(1, 16'h9C40, 16'h63BF, 1);
        for (int i = 0; i < 4; i++) begin
            if (i > 0) drive(0, 16'h0, 16'h0, 1);
            checks++; if (out_valid !== 1'b1 || out_data !== eb[i] || out_last !== el[i]) begin
                errors++; $display("FAIL b2b_byte%0d got=%b/%h/%b exp=1/%h/%b", i, out_valid, out_data, out_last, eb[i], el[i]); end
            tick();
        end
        drive(0, 16'h0, 16'h0, 1);
        checks++; if (count !== '0) begin errors++; $display("FAIL b2b_empty got=%0d exp=0", count); end
    endtask

    task automatic test_integrity();
        drive(1, 16'h1234, 16'h0000, 1);
        tick();
        drive(0, 16'h0, 16'h0, 1);
        checks++; if (count !== '0 || err !== 1'b1 || drop_cnt !== 8'd1) begin
            errors++; $display("FAIL bad_word got=%0d/%b/%0d exp=0/1/1", count, err, drop_cnt); end
        drive(1, 16'h00AA, 16'hFF55, 1);
        tick();
        drive(0, 16'h0, 16'h0, 1);
        checks++; if (out_valid !== 1'b1 || out_data !== 8'h00) begin
            errors++; $display("FAIL after_bad_hi got=%b/%h exp=1/00", out_valid, out_data); end
        tick();
        drive(0, 16'h0, 16'h0, 1);
        checks++; if (out_data !== 8'hAA || out_last !== 1'b1) begin
            errors++; $display("FAIL after_bad_lo got=%h/%b exp=aa/1", out_data, out_last); end
        tick();
        drive(0, 16'h0, 16'h0, 1);
        checks++; if (count !== '0 || err !== 1'b1 || drop_cnt !== 8'd1) begin
            errors++; $display("FAIL err_sticky got=%0d/%b/%0d exp=0/1/1", count, err, drop_cnt); end
    endtask

    task automatic test_full();
        logic [15:0] w[5];
        logic [7:0]  drops;
        drops = drop_cnt;
        for (int i = 0; i < 5; i++) w[i] = 16'($urandom_range(0, 65535));
        for (int i = 0; i < 5; i++) begin
            drive(1, w[i], ~w[i], 0);
            checks++; if (in_ready !== (i < 4)) begin
                errors++; $display("FAIL full_ready%0d got=%b exp=%b", i, in_ready, (i < 4)); end
            tick();
        end
        drive(0, 16'h0, 16'h0, 0);
        checks++; if (count !== CW'(4) || in_ready !== 1'b0 || drop_cnt !== drops) begin
            errors++; $display("FAIL full_state got=%0d/%b/%0d exp=4/0/%0d", count, in_ready, drop_cnt, drops); end
        for (int j = 0; j < 8; j++) begin
            drive(0, 16'h0, 16'h0, 1);
            checks++; if (out_data !== (j[0] ? w[j/2][7:0] : w[j/2][15:8]) || out_last !== j[0]) begin
                errors++; $display("FAIL full_drain%0d got=%h/%b exp=%h/%b", j, out_data, out_last,
                                   (j[0] ? w[j/2][7:0] : w[j/2][15:8]), j[0]); end
            tick();
        end
        drive(0, 16'h0, 16'h0, 0);
        checks++; if (count !== '0) begin errors++; $display("FAIL full_empty got=%0d exp=0", count); end
    endtask

    task automatic test_full_pop();
        logic [15:0] w[5];
        for (int i = 0; i < 5; i++) w[i] = 16'($urandom_range(0, 65535));
        for (int i = 0; i < 4; i++) begin
            drive(1, w[i], ~w[i], 0);
            tick();
        end
        drive(0, 16'h0, 16'h0, 1);
        tick();
        drive(1, w[4], ~w[4], 1);
        checks++; if (count !== CW'(4) || in_ready !== 1'b0 || out_last !== 1'b1 || out_data !== w[0][7:0]) begin
            errors++; $display("FAIL fpop_lo got=%0d/%b/%b/%h exp=4/0/1/%h", count, in_ready, out_last, out_data, w[0][7:0]); end
        tick();
        drive(1, w[4], ~w[4], 0);
        checks++; if (count !== CW'(3) || in_ready !== 1'b1) begin
            errors++; $display("FAIL fpop_nopush got=%0d/%b exp=3/1", count, in_ready); end
        tick();
        drive(0, 16'h0, 16'h0, 0);
        checks++; if (count !== CW'(4)) begin errors++; $display("FAIL fpop_push got=%0d exp=4", count); end
        for (int j = 0; j < 8; j++) begin
            drive(0, 16'h0, 16'h0, 1);
            checks++; if (out_data !== (j[0] ? w[1 + j/2][7:0] : w[1 + j/2][15:8]) || out_last !== j[0]) begin
                errors++; $display("FAIL fpop_drain%0d got=%h/%b exp=%h/%b", j, out_data, out_last,
                                   (j[0] ? w[1 + j/2][7:0] : w[1 + j/2][15:8]), j[0]); end
            tick();
        end
    endtask

    task automatic test_reset_mid();
        drive(1, 16'h0140, 16'hFEBF, 0);
        tick();
        drive(1, 16'h000B, 16'hFFF4, 0);
        tick();
        drive(0, 16'h0, 16'h0, 1);
        tick();
        drive(0, 16'h0, 16'h0, 0);
        checks++; if (count !== CW'(2) || out_last !== 1'b1) begin
            errors++; $display("FAIL mid_pre got=%0d/%b exp=2/1", count, out_last); end
        #2 reset = 1'b0;
        #1;
        checks++; if (count !== '0 || out_valid !== 1'b0 || err !== 1'b0 || drop_cnt !== 8'd0) begin
            errors++; $display("FAIL mid_rst got=%0d/%b/%b/%0d exp=0/0/0/0", count, out_valid, err, drop_cnt); end
        checks++; if (in_ready !== 1'b0 || out_last !== 1'b0) begin
            errors++; $display("FAIL mid_rst_hs got=%b/%b exp=0/0", in_ready, out_last); end
        model_clear();
        @(negedge clk);
        reset = 1'b1;
        tick();
        drive(1, 16'h9C40, 16'h63BF, 1);
        tick();
        drive(0, 16'h0, 16'h0, 1);
        checks++; if (out_valid !== 1'b1 || out_data !== 8'h9C || out_last !== 1'b0) begin
            errors++; $display("FAIL mid_next_hi got=%b/%h/%b exp=1/9c/0", out_valid, out_data, out_last); end
        tick();
        drive(0, 16'h0, 16'h0, 1);
        checks++; if (out_data !== 8'h40 || out_last !== 1'b1) begin
            errors++; $display("FAIL mid_next_lo got=%h/%b exp=40/1", out_data, out_last); end
        tick();
    endtask

    task automatic test_random();
        logic [15:0] w;
        logic [15:0] wb;
        int          cnt;
        for (int n = 0; n < 400; n++) begin
            w  = 16'($urandom_range(0, 65535));
            wb = ($urandom_range(0, 7) == 0) ? 16'($urandom_range(0, 65535)) : ~w;
            drive(logic'($urandom_range(0, 1)), w, wb, logic'($urandom_range(0, 3) != 0));
            cnt = m_count();
            checks++; if (count !== CW'(cnt) || out_valid !== (cnt != 0) || in_ready !== (m_en && cnt < DEPTH)) begin
                errors++; $display("FAIL rnd_flow%0d got=%0d/%b/%b exp=%0d/%b/%b", n, count, out_valid, in_ready,
                                   cnt, (cnt != 0), (m_en && cnt < DEPTH)); end
            checks++; if (err !== m_err || drop_cnt !== 8'(m_drop)) begin
                errors++; $display("FAIL rnd_err%0d got=%b/%0d exp=%b/%0d", n, err, drop_cnt, m_err, m_drop); end
            if (cnt != 0) begin
                checks++; if (out_data !== exp_q[0] || out_last !== exp_q.size() % 2 || state_dbg !== exp_q.size() % 2) begin
                    errors++; $display("FAIL rnd_byte%0d got=%h/%b/%b exp=%h/%b", n, out_data, out_last, state_dbg,
                                       exp_q[0], exp_q.size() % 2); end
            end
            tick();
        end
        for (int k = 0; k < 100 && m_count() != 0; k++) begin
            drive(0, 16'h0, 16'h0, 1);
            tick();
        end
        drive(0, 16'h0, 16'h0, 0);
        checks++; if (count !== '0 || m_count() != 0) begin
            errors++; $display("FAIL rnd_drain_timeout got=%0d model=%0d exp=0", count, m_count()); end
    endtask

    task automatic test_drop_saturate();
        for (int n = 0; n < 260; n++) begin
            drive(1, 16'h5555, 16'h5555, 0);
            tick();
        end
        drive(0, 16'h0, 16'h0, 0);
        checks++; if (drop_cnt !== 8'hFF || err !== 1'b1 || count !== '0) begin
            errors++; $display("FAIL drop_sat got=%0d/%b/%0d exp=255/1/0", drop_cnt, err, count); end
    endtask

    initial begin
        errors    = 0;
        checks    = 0;
        reset     = 1'b0;
        in_valid  = 1'b0;
        Q         = '0;
        Qbar      = '0;
        out_ready = 1'b0;
        model_clear();
        test_reset();
        test_single();
        test_back_to_back();
        test_integrity();
        test_full();
        test_full_pop();
        test_reset_mid();
        test_random();
        test_drop_saturate();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/alu_result_reader.md
ALU_RESULT_READER -- requirements
Module: alu_result_reader

Interface
- REQ-001 The block SHALL have parameter DEPTH, default 4: number of 16-bit result words buffered, power of two, 2..16.
- REQ-002 Port clk  input  1: single clock; all state SHALL update on its rising edge.
- REQ-003 Port reset  input  1: asynchronous, active-low reset; clearing SHALL occur immediately when reset is 0, with no clock required.
- REQ-004 Port in_valid  input  1: Q/Qbar carry a new calculator result this cycle.
- REQ-005 Port in_ready  output  1: the block can accept a word this cycle.
- REQ-006 Port Q  input  16: registered calculator result.
- REQ-007 Port Qbar  input  16: complement output of the calculator result register.
- REQ-008 Port out_data  output  8: byte presented to the downstream consumer.
- REQ-009 Port out_valid  output  1: out_data is valid.
- REQ-010 Port out_ready  input  1: the consumer accepts out_data this cycle.
- REQ-011 Port out_last  output  1: marks the low byte, the second and final byte of a word.
- REQ-012 Port count  output  log2(DEPTH)+1: number of words stored, 0..DEPTH.
- REQ-013 Port err  output  1: sticky integrity error flag.
- REQ-014 Port drop_cnt  output  8: saturating count of rejected words.

Function
- REQ-015 in_ready SHALL equal (count < DEPTH), using the registered count only; a pop in the same cycle SHALL NOT free a slot for a push in that cycle.
- REQ-016 A push attempt SHALL occur when in_valid=1 and in_ready=1.
- REQ-017 On a push attempt with Qbar == ~Q, Q SHALL be written at the write pointer, the write pointer SHALL advance modulo DEPTH, and count SHALL increment.
- REQ-018 On a push attempt with Qbar != ~Q:
  - the word SHALL NOT be stored;
  - err SHALL be set to 1;
  - drop_cnt SHALL increment, saturating at 255.
- REQ-019 While in_ready=0, in_valid SHALL be ignored: no store, no error, no drop count.
- REQ-020 out_valid SHALL equal (count != 0).
- REQ-021 Output FSM state HI:
  - out_data SHALL be head[15:8];
  - out_last SHALL be 0;
  - on out_valid & out_ready, the FSM SHALL go to LO.
- REQ-022 Output FSM state LO:
  - out_data SHALL be head[7:0];
  - out_last SHALL be 1;
  - on out_valid & out_ready, the word SHALL be popped, the read pointer SHALL advance modulo DEPTH, count SHALL decrement, and the FSM SHALL go to HI.
- REQ-023 While out_valid=1 and out_ready=0, out_data and out_last SHALL hold stable.
- REQ-024 A word pushed into an empty buffer SHALL appear on out_data, with out_valid=1, in the cycle after the push edge (latency 1).
- REQ-025 On a simultaneous push and pop, count SHALL be unchanged and both pointers SHALL advance.
- REQ-026 While out_valid=0, the FSM SHALL remain in HI; out_data is don't-care.

Reset
- REQ-027 While reset=0, the block SHALL hold: count=0, both pointers=0, FSM=HI, out_valid=0, out_last=0, in_ready=0, err=0, drop_cnt=0.
- REQ-028 A reset asserted mid-word, after the high byte was accepted, SHALL discard all stored words; after release, the next word SHALL start at its high byte.
- REQ-029 Buffer storage contents need not be cleared by reset.
- REQ-030 in_ready SHALL rise in the first cycle after reset deasserts.

Verification
- REQ-031 Push Q=0x0140, Qbar=0xFEBF (220+100), out_ready=1 -> next cycle out_data=0x01 with out_last=0, then out_data=0x40 with out_last=1, then count=0.
- REQ-032 Push 0x000B (211-200), then 0x9C40 (200*200) back-to-back, out_ready=1 -> byte stream 0x00, 0x0B, 0x9C, 0x40, with out_last on the 2nd and 4th bytes.
- REQ-033 Push Q=0x1234, Qbar=0x0000 -> count stays 0, err=1, drop_cnt=1; a following valid word SHALL still be delivered with err remaining 1.
- REQ-034 out_ready=0, push 5 valid words -> count=4, in_ready=0, 5th word not stored; release out_ready -> 8 bytes of the first 4 words, in order.
- REQ-035 Full buffer, in_valid=1, and LO-byte pop in the same cycle -> no push that cycle, count=3; push occurs the next cycle.
- REQ-036 Reset pulsed low after HI byte accepted with 2 words stored -> count=0, out_valid=0, err=0 immediately; next pushed word 0x9C40 -> 0x9C first.
